// File: rtl/sf_correlator_mc_if.sv
// Bus bundle for sf_correlator_mc: the sample/coefficient input side and the
// result FIFO output side. slave = correlator view, master = driver/consumer view.
interface sf_correlator_mc_if #(
  parameter int CHANELS      = 4,
  parameter int N_INPUTS     = 2,
  parameter int X_WIDTH      = 16,
  parameter int W_WIDTH      = 16,
  parameter int S_WIDTH      = 38,
  parameter int FRAME_LENGTH = 22
);
  localparam int CH_W  = $clog2(CHANELS);
  localparam int IDX_W = (FRAME_LENGTH > 1) ? $clog2(FRAME_LENGTH) : 1;

  logic                         i_vld;
  logic [N_INPUTS*X_WIDTH-1:0]  x;
  logic [CH_W-1:0]              address_registration;
  logic [IDX_W-1:0]             sample_idx;
  logic signed [W_WIDTH-1:0]    w_re;
  logic signed [W_WIDTH-1:0]    w_im;
  logic                         acc_finish;
  logic                         o_vld;
  logic                         o_ready;
  logic [CH_W-1:0]              address_output;
  logic [N_INPUTS*S_WIDTH-1:0]  o_re;
  logic [N_INPUTS*S_WIDTH-1:0]  o_im;
  logic                         o_drop;

  modport slave (
    input  i_vld, x, address_registration, w_re, w_im, o_ready,
    output sample_idx, acc_finish, o_vld, address_output, o_re, o_im, o_drop
  );

  modport master (
    output i_vld, x, address_registration, w_re, w_im, o_ready,
    input  sample_idx, acc_finish, o_vld, address_output, o_re, o_im, o_drop
  );
endinterface

// File: rtl/sf_correlator_mc.sv
// Multi-channel single-frequency DFT correlator.
// Stage 1 registers the lane products and advances the addressed channel's
// sample/frame counters; stage 2 accumulates into that channel's context and,
// on the last sample of an averaging set, pushes the mean into a result FIFO.
// Optional: define SF_CORRELATOR_ROUND_EN for round-half-up averaging instead
// of a truncating arithmetic shift (no difference when MEAN_STEPS = 0).
module sf_correlator_mc #(
  parameter int CHANELS      = 4,
  parameter int N_INPUTS     = 2,
  parameter int X_WIDTH      = 16,
  parameter int W_WIDTH      = 16,
  parameter int S_WIDTH      = 38,
  parameter int FRAME_LENGTH = 22,
  parameter int MEAN_STEPS   = 0,
  parameter int OUT_DEPTH    = 4
) (
  input logic               clk,
  input logic               rstn,
  sf_correlator_mc_if.slave bus
);
  localparam int CH_W    = $clog2(CHANELS);
  localparam int IDX_W   = (FRAME_LENGTH > 1) ? $clog2(FRAME_LENGTH) : 1;
  localparam int FRM_W   = (MEAN_STEPS > 0) ? MEAN_STEPS : 1;
  localparam int P_WIDTH = X_WIDTH + W_WIDTH;
  localparam int AW      = $clog2(OUT_DEPTH);
  localparam logic [IDX_W-1:0] LAST_SMP = IDX_W'(FRAME_LENGTH - 1);
  localparam logic [FRM_W-1:0] LAST_FRM = FRM_W'((2 ** MEAN_STEPS) - 1);
  localparam logic [AW:0]      FULL_CNT = (AW + 1)'(OUT_DEPTH);
`ifdef SF_CORRELATOR_ROUND_EN
  localparam logic signed [S_WIDTH-1:0] RND = S_WIDTH'((2 ** MEAN_STEPS) / 2);
`else
  localparam logic signed [S_WIDTH-1:0] RND = '0;
`endif

  // per-channel counters
  logic [IDX_W-1:0] r_smp_cnt [CHANELS];
  logic [FRM_W-1:0] r_frm_cnt [CHANELS];

  // stage 1 pipeline
  logic                      r_s1_vld;
  logic                      r_s1_last;
  logic [CH_W-1:0]           r_s1_ch;
  logic signed [P_WIDTH-1:0] r_p_re [N_INPUTS];
  logic signed [P_WIDTH-1:0] r_p_im [N_INPUTS];

  // per-channel accumulators
  logic signed [S_WIDTH-1:0] r_acc_re [CHANELS][N_INPUTS];
  logic signed [S_WIDTH-1:0] r_acc_im [CHANELS][N_INPUTS];
  logic                      r_fin;

  // result FIFO
  logic signed [S_WIDTH-1:0] r_fifo_re [OUT_DEPTH][N_INPUTS];
  logic signed [S_WIDTH-1:0] r_fifo_im [OUT_DEPTH][N_INPUTS];
  logic [CH_W-1:0]           r_fifo_ch [OUT_DEPTH];
  logic [AW-1:0]             r_wr;
  logic [AW-1:0]             r_rd;
  logic [AW:0]               r_cnt;
  logic                      r_drop;

  logic [CH_W-1:0]           w_ch;
  logic                      w_smp_wrap;
  logic                      w_frm_wrap;
  logic signed [X_WIDTH-1:0] w_x      [N_INPUTS];
  logic signed [P_WIDTH-1:0] w_prod_re [N_INPUTS];
  logic signed [P_WIDTH-1:0] w_prod_im [N_INPUTS];
  logic signed [P_WIDTH-1:0] w_wre;
  logic signed [P_WIDTH-1:0] w_wim;
  logic signed [S_WIDTH-1:0] w_sum_re  [N_INPUTS];
  logic signed [S_WIDTH-1:0] w_sum_im  [N_INPUTS];
  logic signed [S_WIDTH-1:0] w_mean_re [N_INPUTS];
  logic signed [S_WIDTH-1:0] w_mean_im [N_INPUTS];
  logic                      w_push;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_wr;
  logic [N_INPUTS*S_WIDTH-1:0] w_o_re;
  logic [N_INPUTS*S_WIDTH-1:0] w_o_im;

  assign w_ch       = bus.address_registration;
  assign w_smp_wrap = (r_smp_cnt[w_ch] == LAST_SMP);
  assign w_frm_wrap = (r_frm_cnt[w_ch] == LAST_FRM);
  assign w_wre      = P_WIDTH'(bus.w_re);
  assign w_wim      = P_WIDTH'(bus.w_im);

  // Full-precision products of every input lane with the current coefficients
  always_comb begin
    for (int k = 0; k < N_INPUTS; k++) begin
      w_x[k]       = bus.x[k*X_WIDTH +: X_WIDTH];
      w_prod_re[k] = P_WIDTH'(w_x[k]) * w_wre;
      w_prod_im[k] = P_WIDTH'(w_x[k]) * w_wim;
    end
  end

  // Stage 1: capture products, advance the addressed channel's counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < CHANELS; c++) begin
        r_smp_cnt[c] <= '0;
        r_frm_cnt[c] <= '0;
      end
      for (int k = 0; k < N_INPUTS; k++) begin
        r_p_re[k] <= '0;
        r_p_im[k] <= '0;
      end
      r_s1_vld  <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_ch   <= '0;
    end else begin
      r_s1_vld <= bus.i_vld;
      if (bus.i_vld) begin
        r_s1_ch   <= w_ch;
        r_s1_last <= w_smp_wrap && w_frm_wrap;
        for (int k = 0; k < N_INPUTS; k++) begin
          r_p_re[k] <= w_prod_re[k];
          r_p_im[k] <= w_prod_im[k];
        end
        if (w_smp_wrap) begin
          r_smp_cnt[w_ch] <= '0;
          r_frm_cnt[w_ch] <= w_frm_wrap ? '0 : r_frm_cnt[w_ch] + FRM_W'(1);
        end else begin
          r_smp_cnt[w_ch] <= r_smp_cnt[w_ch] + IDX_W'(1);
        end
      end
    end
  end

  // Running sums and the averaged result for the channel in stage 2
  always_comb begin
    for (int k = 0; k < N_INPUTS; k++) begin
      w_sum_re[k]  = r_acc_re[r_s1_ch][k] + S_WIDTH'(r_p_re[k]);
      w_sum_im[k]  = r_acc_im[r_s1_ch][k] + S_WIDTH'(r_p_im[k]);
      w_mean_re[k] = (w_sum_re[k] + RND) >>> MEAN_STEPS;
      w_mean_im[k] = (w_sum_im[k] + RND) >>> MEAN_STEPS;
    end
  end

  assign w_push = r_s1_vld && r_s1_last;
  assign w_full = (r_cnt == FULL_CNT);
  assign w_pop  = (r_cnt != '0) && bus.o_ready;
  // a pop on the same edge frees the slot, so a full FIFO still accepts
  assign w_wr   = w_push && (!w_full || w_pop);

  // Stage 2: accumulate (read-modify-write in one cycle, so back-to-back
  // samples of one channel see the freshly written sum), clear on completion
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < CHANELS; c++) begin
        for (int k = 0; k < N_INPUTS; k++) begin
          r_acc_re[c][k] <= '0;
          r_acc_im[c][k] <= '0;
        end
      end
      r_fin <= 1'b0;
    end else begin
      r_fin <= w_push;
      if (r_s1_vld) begin
        for (int k = 0; k < N_INPUTS; k++) begin
          r_acc_re[r_s1_ch][k] <= w_push ? '0 : w_sum_re[k];
          r_acc_im[r_s1_ch][k] <= w_push ? '0 : w_sum_im[k];
        end
      end
    end
  end

  // Result FIFO with sticky overflow flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int e = 0; e < OUT_DEPTH; e++) begin
        r_fifo_ch[e] <= '0;
        for (int k = 0; k < N_INPUTS; k++) begin
          r_fifo_re[e][k] <= '0;
          r_fifo_im[e][k] <= '0;
        end
      end
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_drop <= 1'b0;
    end else begin
      if (w_wr) begin
        r_fifo_ch[r_wr] <= r_s1_ch;
        for (int k = 0; k < N_INPUTS; k++) begin
          r_fifo_re[r_wr][k] <= w_mean_re[k];
          r_fifo_im[r_wr][k] <= w_mean_im[k];
        end
        r_wr <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      if (w_push && !w_wr) r_drop <= 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW + 1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW + 1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Pack the FIFO head onto the output lanes
  always_comb begin
    w_o_re = '0;
    w_o_im = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      w_o_re[k*S_WIDTH +: S_WIDTH] = r_fifo_re[r_rd][k];
      w_o_im[k*S_WIDTH +: S_WIDTH] = r_fifo_im[r_rd][k];
    end
  end

  assign bus.sample_idx     = r_smp_cnt[w_ch];
  assign bus.acc_finish     = r_fin;
  assign bus.o_vld          = (r_cnt != '0);
  assign bus.address_output = r_fifo_ch[r_rd];
  assign bus.o_re           = w_o_re;
  assign bus.o_im           = w_o_im;
  assign bus.o_drop         = r_drop;
endmodule

// File: tb/tb_sf_correlator_mc.sv
// Bench for sf_correlator_mc: two instances (A: MEAN_STEPS=0, depth 2;
// B: MEAN_STEPS=1, depth 4) checked every cycle against a sum/queue model,
// plus literal expectations on the results popped from each.
module tb_sf_correlator_mc;
  localparam int CH = 4, NI = 2, XW = 16, WW = 16, SW = 38, FL = 4, CW = 2;
`ifdef SF_CORRELATOR_ROUND_EN
  localparam longint AVG0 = 12, AVG1 = -11;
`else
  localparam longint AVG0 = 11, AVG1 = -12;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sf_correlator_mc_if #(.CHANELS(CH), .N_INPUTS(NI), .X_WIDTH(XW), .W_WIDTH(WW),
                        .S_WIDTH(SW), .FRAME_LENGTH(FL)) ifa ();
  sf_correlator_mc_if #(.CHANELS(CH), .N_INPUTS(NI), .X_WIDTH(XW), .W_WIDTH(WW),
                        .S_WIDTH(SW), .FRAME_LENGTH(FL)) ifb ();

  sf_correlator_mc #(.CHANELS(CH), .N_INPUTS(NI), .X_WIDTH(XW), .W_WIDTH(WW), .S_WIDTH(SW),
                     .FRAME_LENGTH(FL), .MEAN_STEPS(0), .OUT_DEPTH(2))
    u_dut_a (.clk(clk), .rstn(rstn), .bus(ifa.slave));
  sf_correlator_mc #(.CHANELS(CH), .N_INPUTS(NI), .X_WIDTH(XW), .W_WIDTH(WW), .S_WIDTH(SW),
                     .FRAME_LENGTH(FL), .MEAN_STEPS(1), .OUT_DEPTH(4))
    u_dut_b (.clk(clk), .rstn(rstn), .bus(ifb.slave));

  typedef struct {
    int     ch;
    longint re0, im0, re1, im1;
  } res_t;

  int n_pass = 0;
  int n_total = 0;

  // model state, index 0 = A, 1 = B
  int     ms_of  [2] = '{0, 1};
  int     dep_of [2] = '{2, 4};
  int     m_smp  [2][CH];
  int     m_frm  [2][CH];
  longint m_re   [2][CH][NI];
  longint m_im   [2][CH][NI];
  res_t   m_fifo [2][4];
  int     m_head [2];
  int     m_cnt  [2];
  bit     m_pend [2];
  res_t   m_pres [2];
  bit     m_fin  [2];
  bit     m_drop [2];

  res_t loga[$];
  res_t logb[$];

  task automatic check(input int d, input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s.%s: got %0d expected %0d at %0t", (d == 0) ? "A" : "B", nm, act, exp, $time);
  endtask

  function automatic longint mean_of(input longint s, input int ms);
    longint t;
    t = s;
`ifdef SF_CORRELATOR_ROUND_EN
    if (ms > 0) t = t + (longint'(1) << (ms - 1));
`endif
    return t >>> ms;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < CH; c++) begin
        m_smp[d][c] = 0;
        m_frm[d][c] = 0;
        for (int k = 0; k < NI; k++) begin
          m_re[d][c][k] = 0;
          m_im[d][c][k] = 0;
        end
      end
      m_head[d] = 0; m_cnt[d] = 0; m_pend[d] = 1'b0; m_fin[d] = 1'b0; m_drop[d] = 1'b0;
    end
  endtask

  // One clock edge of the behavioural model: pop, deliver last edge's result, accept sample
  task automatic model_step(input int d, input bit vld, input int ch, input longint x0,
                            input longint x1, input longint wr, input longint wi, input bit rdy);
    longint xv [NI];
    xv[0] = x0;
    xv[1] = x1;
    if (m_cnt[d] > 0 && rdy) begin
      m_head[d] = (m_head[d] + 1) % dep_of[d];
      m_cnt[d]--;
    end
    m_fin[d] = m_pend[d];
    if (m_pend[d]) begin
      if (m_cnt[d] < dep_of[d]) begin
        m_fifo[d][(m_head[d] + m_cnt[d]) % dep_of[d]] = m_pres[d];
        m_cnt[d]++;
      end else begin
        m_drop[d] = 1'b1;
      end
      m_pend[d] = 1'b0;
    end
    if (vld) begin
      for (int k = 0; k < NI; k++) begin
        m_re[d][ch][k] += xv[k] * wr;
        m_im[d][ch][k] += xv[k] * wi;
      end
      m_smp[d][ch]++;
      if (m_smp[d][ch] == FL) begin
        m_smp[d][ch] = 0;
        m_frm[d][ch]++;
        if (m_frm[d][ch] == (1 << ms_of[d])) begin
          m_frm[d][ch] = 0;
          m_pres[d].ch  = ch;
          m_pres[d].re0 = mean_of(m_re[d][ch][0], ms_of[d]);
          m_pres[d].im0 = mean_of(m_im[d][ch][0], ms_of[d]);
          m_pres[d].re1 = mean_of(m_re[d][ch][1], ms_of[d]);
          m_pres[d].im1 = mean_of(m_im[d][ch][1], ms_of[d]);
          m_pend[d] = 1'b1;
          for (int k = 0; k < NI; k++) begin
            m_re[d][ch][k] = 0;
            m_im[d][ch][k] = 0;
          end
        end
      end
    end
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) model_reset();
    else begin
      model_step(0, ifa.i_vld, int'(ifa.address_registration), longint'($signed(ifa.x[XW-1:0])),
                 longint'($signed(ifa.x[2*XW-1:XW])), longint'(ifa.w_re), longint'(ifa.w_im), ifa.o_ready);
      model_step(1, ifb.i_vld, int'(ifb.address_registration), longint'($signed(ifb.x[XW-1:0])),
                 longint'($signed(ifb.x[2*XW-1:XW])), longint'(ifb.w_re), longint'(ifb.w_im), ifb.o_ready);
    end
  end

  task automatic cmp_dut(input int d, input logic [CW-1:0] ch_in, input logic [1:0] sidx,
                         input logic fin, input logic vld, input logic drop, input logic [CW-1:0] addr,
                         input logic [NI*SW-1:0] ore, input logic [NI*SW-1:0] oim, input logic rdy);
    res_t h;
    res_t g;
    g.ch  = int'(addr);
    g.re0 = longint'($signed(ore[SW-1:0]));
    g.re1 = longint'($signed(ore[2*SW-1:SW]));
    g.im0 = longint'($signed(oim[SW-1:0]));
    g.im1 = longint'($signed(oim[2*SW-1:SW]));
    check(d, "sample_idx", longint'(sidx), longint'(m_smp[d][ch_in]));
    check(d, "acc_finish", longint'(fin), longint'(m_fin[d]));
    check(d, "o_drop", longint'(drop), longint'(m_drop[d]));
    check(d, "o_vld", longint'(vld), longint'(m_cnt[d] > 0));
    if (m_cnt[d] > 0) begin
      h = m_fifo[d][m_head[d]];
      check(d, "address_output", longint'(g.ch), longint'(h.ch));
      check(d, "o_re0", g.re0, h.re0);
      check(d, "o_im0", g.im0, h.im0);
      check(d, "o_re1", g.re1, h.re1);
      check(d, "o_im1", g.im1, h.im1);
    end
    if (!rstn) begin
      check(d, "rst_o_re", longint'(ore != '0), 0);
      check(d, "rst_o_im", longint'(oim != '0), 0);
      check(d, "rst_addr", longint'(addr), 0);
    end
    if (vld && rdy) begin
      if (d == 0) loga.push_back(g);
      else logb.push_back(g);
    end
  endtask

  always @(negedge clk) begin
    cmp_dut(0, ifa.address_registration, ifa.sample_idx, ifa.acc_finish, ifa.o_vld, ifa.o_drop,
            ifa.address_output, ifa.o_re, ifa.o_im, ifa.o_ready);
    cmp_dut(1, ifb.address_registration, ifb.sample_idx, ifb.acc_finish, ifb.o_vld, ifb.o_drop,
            ifb.address_output, ifb.o_re, ifb.o_im, ifb.o_ready);
  end

  task automatic step(input int d, input bit v, input int ch, input int x0, input int x1);
    @(posedge clk);
    #1;
    if (d == 0) begin
      ifa.i_vld = v; ifa.address_registration = CW'(ch); ifa.x = {XW'(x1), XW'(x0)};
      ifb.i_vld = 1'b0;
    end else begin
      ifb.i_vld = v; ifb.address_registration = CW'(ch); ifb.x = {XW'(x1), XW'(x0)};
      ifa.i_vld = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 1'b0, 3, 0, 0);
  endtask

  task automatic chk_log(input int d, input int idx, input int ch, input longint re0,
                         input longint im0, input longint re1, input longint im1);
    res_t r;
    int sz;
    sz = (d == 0) ? loga.size() : logb.size();
    check(d, "log_present", longint'(sz > idx), 1);
    if (sz > idx) begin
      if (d == 0) r = loga[idx];
      else r = logb[idx];
      check(d, "log_ch", longint'(r.ch), longint'(ch));
      check(d, "log_re0", r.re0, re0);
      check(d, "log_im0", r.im0, im0);
      check(d, "log_re1", r.re1, re1);
      check(d, "log_im1", r.im1, im1);
    end
  endtask

  initial begin
    model_reset();
    ifa.i_vld = 1'b0; ifa.x = '0; ifa.address_registration = '0; ifa.o_ready = 1'b1;
    ifa.w_re = WW'(1); ifa.w_im = '0;
    ifb.i_vld = 1'b0; ifb.x = '0; ifb.address_registration = '0; ifb.o_ready = 1'b1;
    ifb.w_re = WW'(1); ifb.w_im = '0;
    idle(3);
    rstn = 1'b1;
    idle(2);

    // base frame on channel 0 with literal latency pins
    for (int i = 1; i <= 4; i++) step(0, 1'b1, 0, i, 0);
    step(0, 1'b0, 0, 0, 0);
    check(0, "lat_vld_edgeN", longint'(ifa.o_vld), 0);
    step(0, 1'b0, 0, 0, 0);
    check(0, "lat_vld_edgeN1", longint'(ifa.o_vld), 1);
    check(0, "lat_fin_edgeN1", longint'(ifa.acc_finish), 1);
    check(0, "lat_re_edgeN1", longint'($signed(ifa.o_re[SW-1:0])), 10);
    step(0, 1'b0, 0, 0, 0);
    check(0, "fin_single_pulse", longint'(ifa.acc_finish), 0);
    idle(2);
    chk_log(0, 0, 0, 10, 0, 0, 0);

    // interleaved channels 0 and 1
    for (int i = 1; i <= 4; i++) begin
      step(0, 1'b1, 0, i, 0);
      step(0, 1'b1, 1, 10 * i, 0);
    end
    idle(4);
    chk_log(0, 1, 0, 10, 0, 0, 0);
    chk_log(0, 2, 1, 100, 0, 0, 0);

    // negative samples and coefficients, both lanes
    ifa.w_re = WW'(-2); ifa.w_im = WW'(3);
    repeat (4) step(0, 1'b1, 2, -3, -3);
    idle(4);
    chk_log(0, 3, 2, 24, -36, 24, -36);

    // backpressure: three frames into a depth-2 FIFO
    ifa.w_re = WW'(1); ifa.w_im = '0; ifa.o_ready = 1'b0;
    for (int f = 1; f <= 3; f++) repeat (4) step(0, 1'b1, 0, f, 0);
    idle(4);
    check(0, "bp_drop", longint'(ifa.o_drop), 1);
    check(0, "bp_vld", longint'(ifa.o_vld), 1);
    check(0, "bp_head_re", longint'($signed(ifa.o_re[SW-1:0])), 4);
    ifa.o_ready = 1'b1;
    idle(4);
    check(0, "bp_pop_count", longint'(loga.size()), 6);
    chk_log(0, 4, 0, 4, 0, 0, 0);
    chk_log(0, 5, 0, 8, 0, 0, 0);
    check(0, "bp_drop_sticky", longint'(ifa.o_drop), 1);

    // averaging over two frames on instance B, channel 1
    step(1, 1'b1, 1, 1, -1); step(1, 1'b1, 1, 2, -2); step(1, 1'b1, 1, 3, -3); step(1, 1'b1, 1, 4, -4);
    idle(3);
    check(1, "avg_no_early_result", longint'(logb.size()), 0);
    step(1, 1'b1, 1, 2, -2); step(1, 1'b1, 1, 3, -3); step(1, 1'b1, 1, 4, -4); step(1, 1'b1, 1, 4, -4);
    idle(4);
    chk_log(1, 0, 1, AVG0, 0, AVG1, 0);

    // reset in the middle of a frame on A
    step(0, 1'b1, 0, 1, 0);
    step(0, 1'b1, 0, 2, 0);
    step(0, 1'b0, 0, 0, 0);
    rstn = 1'b0;
    #1;
    check(0, "rst_drop", longint'(ifa.o_drop), 0);
    check(0, "rst_vld", longint'(ifa.o_vld), 0);
    check(0, "rst_fin", longint'(ifa.acc_finish), 0);
    idle(2);
    rstn = 1'b1;
    idle(1);
    for (int i = 1; i <= 4; i++) step(0, 1'b1, 0, i, 0);
    idle(5);
    check(0, "post_rst_count", longint'(loga.size()), 7);
    chk_log(0, 6, 0, 10, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
